obm_dma: RTL and testbench

OBM_DMA -- requirements
Module: obm_dma

---
 rtl/mapache64.sv | 25 ++
 rtl/vram_port_mux.sv | 38 +++
 rtl/obm_dma.sv | 131 +++++++++++++
 tb/tb_obm_dma.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mapache64.sv
// Shared mapache64 definitions for the OBM DMA: state encoding and default OBM geometry.
// WAIT_VBL exists only when OBM_DMA_VBLANK_WAIT_EN is defined.
package mapache64;

    localparam logic [11:0] OBM_BASE_ADDR = 12'h800;
    localparam int          OBM_NUM_BYTES = 256;

`ifdef OBM_DMA_VBLANK_WAIT_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VBL = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        DONE     = 3'd4
    } obm_dma_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } obm_dma_state_t;
`endif

endpackage

// File: rtl/vram_port_mux.sv
// VRAM port arbiter: the CPU owns the port while the DMA is idle; otherwise the DMA
// drives it and only ever targets object memory.
module vram_port_mux (
    input  logic        dma_active,
    input  logic        dma_wen,
    input  logic [11:0] dma_address,
    input  logic [7:0]  dma_data,
    input  logic [11:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wen,
    input  logic        cpu_sel_pmf,
    input  logic        cpu_sel_obm,
    output logic [11:0] vram_address,
    output logic [7:0]  vram_data,
    output logic        vram_wen,
    output logic        vram_sel_pmf,
    output logic        vram_sel_obm
);

    // Select the port owner; CPU inputs are fully ignored while the DMA is active.
    always_comb begin
        vram_address = cpu_address;
        vram_data    = cpu_data;
        vram_wen     = cpu_wen;
        vram_sel_pmf = cpu_sel_pmf;
        vram_sel_obm = cpu_sel_obm;
        if (dma_active) begin
            vram_address = dma_address;
            vram_data    = dma_data;
            vram_wen     = dma_wen;
            vram_sel_pmf = 1'b0;
            vram_sel_obm = 1'b1;
        end else begin
            vram_wen     = cpu_wen;
        end
    end

endmodule

// File: rtl/obm_dma.sv
// OBM DMA: copies OBM_BYTES bytes from a work-RAM page into VRAM object memory while
// stalling the CPU. Define OBM_DMA_VBLANK_WAIT_EN to hold the copy until vertical blank.
module obm_dma
    import mapache64::*;
#(
    parameter int          OBM_BYTES = OBM_NUM_BYTES,
    parameter logic [11:0] OBM_BASE  = OBM_BASE_ADDR
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  page_i,
    input  logic        vblank_i,
    output logic [15:0] mem_address_o,
    output logic        mem_ren_o,
    input  logic [7:0]  mem_data_i,
    input  logic [11:0] cpu_vram_address_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_wen_i,
    input  logic        cpu_SELECT_pmf_i,
    input  logic        cpu_SELECT_obm_i,
    output logic [11:0] vram_address_o,
    output logic [7:0]  data_o,
    output logic        wen_o,
    output logic        SELECT_pmf_o,
    output logic        SELECT_obm_o,
    output logic        cpu_stall_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int             IDX_W    = $clog2(OBM_BYTES) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OBM_BYTES - 1);

    obm_dma_state_t   state_r, state_next_s;
    logic [IDX_W-1:0] idx_r, idx_next_s;
    logic [7:0]       page_r, page_next_s;
    logic             busy_r, stall_r, done_r;
    logic             dma_active_s, dma_wen_s;
    logic [11:0]      dma_address_s;

    // Next-state, byte index and page register updates.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        page_next_s  = page_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    page_next_s = page_i;
                    idx_next_s  = {IDX_W{1'b0}};
`ifdef OBM_DMA_VBLANK_WAIT_EN
                    state_next_s = WAIT_VBL;
`else
                    state_next_s = READ;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
`ifdef OBM_DMA_VBLANK_WAIT_EN
            WAIT_VBL: begin
                if (vblank_i) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = WAIT_VBL;
                end
            end
`endif
            READ:  state_next_s = WRITE;
            WRITE: begin
                idx_next_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                if (idx_r == IDX_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = READ;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, index, page and lookahead-registered status flags.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            page_r  <= 8'h00;
            busy_r  <= 1'b0;
            stall_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            page_r  <= page_next_s;
            busy_r  <= (state_next_s != IDLE);
            stall_r <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
        end
    end

    // The page byte is fixed for the transfer; only the low address byte walks.
    assign mem_address_o = {page_r, 8'(idx_r)};
    assign mem_ren_o     = (state_r == READ);
    assign cpu_stall_o   = stall_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;

    assign dma_active_s  = (state_r != IDLE);
    assign dma_wen_s     = (state_r == WRITE);
    assign dma_address_s = OBM_BASE + 12'(idx_r);

    vram_port_mux u_vram_port_mux (
        .dma_active   (dma_active_s),
        .dma_wen      (dma_wen_s),
        .dma_address  (dma_address_s),
        .dma_data     (mem_data_i),
        .cpu_address  (cpu_vram_address_i),
        .cpu_data     (cpu_data_i),
        .cpu_wen      (cpu_wen_i),
        .cpu_sel_pmf  (cpu_SELECT_pmf_i),
        .cpu_sel_obm  (cpu_SELECT_obm_i),
        .vram_address (vram_address_o),
        .vram_data    (data_o),
        .vram_wen     (wen_o),
        .vram_sel_pmf (SELECT_pmf_o),
        .vram_sel_obm (SELECT_obm_o)
    );

endmodule

// File: tb/tb_obm_dma.sv
// Scoreboard bench for obm_dma: stimulus pushes expected VRAM writes, a negedge monitor
// pops and compares them, and also checks every work-RAM read address.
module tb_obm_dma;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
        logic        pmf;
        logic        obm;
    } wr_t;

    localparam logic [11:0] BASE = 12'h800;

    logic        cpu_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  page_i = 8'h00;
    logic        vblank_i = 1'b1;
    logic [15:0] mem_address_o;
    logic        mem_ren_o;
    logic [7:0]  mem_data_i = 8'h00;
    logic [11:0] cpu_vram_address_i = 12'h000;
    logic [7:0]  cpu_data_i = 8'h00;
    logic        cpu_wen_i = 1'b0;
    logic        cpu_SELECT_pmf_i = 1'b0;
    logic        cpu_SELECT_obm_i = 1'b0;
    logic [11:0] vram_address_o;
    logic [7:0]  data_o;
    logic        wen_o;
    logic        SELECT_pmf_o;
    logic        SELECT_obm_o;
    logic        cpu_stall_o;
    logic        busy_o;
    logic        done_o;

    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    int   done_cnt = 0;
    wr_t  exp_q[$];
    wr_t  got_w, exp_w;
    logic [7:0] exp_page = 8'h00;
    logic [7:0] rd_k = 8'h00;
    logic [7:0] obm_m [0:255];

    obm_dma dut (
        .cpu_clk(cpu_clk), .rst_n(rst_n), .start_i(start_i), .page_i(page_i),
        .vblank_i(vblank_i), .mem_address_o(mem_address_o), .mem_ren_o(mem_ren_o),
        .mem_data_i(mem_data_i), .cpu_vram_address_i(cpu_vram_address_i),
        .cpu_data_i(cpu_data_i), .cpu_wen_i(cpu_wen_i),
        .cpu_SELECT_pmf_i(cpu_SELECT_pmf_i), .cpu_SELECT_obm_i(cpu_SELECT_obm_i),
        .vram_address_o(vram_address_o), .data_o(data_o), .wen_o(wen_o),
        .SELECT_pmf_o(SELECT_pmf_o), .SELECT_obm_o(SELECT_obm_o),
        .cpu_stall_o(cpu_stall_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [7:0] ram_f(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
        else return a[7:0] ^ 8'h5A;
    endfunction

    // Work-RAM model: data one cycle after the read strobe.
    always @(posedge cpu_clk) begin
        if (mem_ren_o) mem_data_i <= ram_f(mem_address_o);
    end

    // Monitor: read addresses, done pulses and every VRAM write against the scoreboard.
    always @(negedge cpu_clk) begin
        if (rst_n) begin
            if (done_o) done_cnt++;
            if (mem_ren_o) begin
                checks++;
                if (mem_address_o !== {exp_page, rd_k}) begin
                    errors++;
                    $display("FAIL rd_addr: got %h want %h", mem_address_o, {exp_page, rd_k});
                end
                rd_k++;
            end
            if (wen_o) begin
                wr_count++;
                checks++;
                got_w = '{vram_address_o, data_o, SELECT_pmf_o, SELECT_obm_o};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr: got a=%h d=%h pmf=%b obm=%b want none",
                             got_w.a, got_w.d, got_w.pmf, got_w.obm);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("FAIL vram_wr: got a=%h d=%h pmf=%b obm=%b want a=%h d=%h pmf=%b obm=%b",
                                 got_w.a, got_w.d, got_w.pmf, got_w.obm,
                                 exp_w.a, exp_w.d, exp_w.pmf, exp_w.obm);
                    end
                end
                if (SELECT_obm_o && vram_address_o >= BASE && vram_address_o < BASE + 12'd256)
                    obm_m[8'(vram_address_o - BASE)] = data_o;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cpu_drive(input logic en);
        cpu_wen_i          = en;
        cpu_vram_address_i = 12'h000;
        cpu_data_i         = 8'h3C;
        cpu_SELECT_pmf_i   = 1'b1;
        cpu_SELECT_obm_i   = 1'b0;
    endtask

    task automatic check_obm(input string name, input int valid_upto, input logic [7:0] fill);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (k < valid_upto) begin
                if (obm_m[k] !== (8'(k) ^ 8'hA5)) bad++;
            end else begin
                if (obm_m[k] !== fill) bad++;
            end
        end
        chk(name, bad, 0);
    endtask

    task automatic run_xfer(input logic [7:0] pg, input int restart_at, input int cpu_wr_at,
                            input bit cpu_at_start, input int abort_after, input int vbl_low);
        int n, done_n, base_wr, base_done, exp_done;
        bit got, aborted;
        if (cpu_at_start) exp_q.push_back('{12'h000, 8'h3C, 1'b1, 1'b0});
        for (int k = 0; k < 256; k++)
            exp_q.push_back('{BASE + 12'(k), ram_f({pg, 8'(k)}), 1'b0, 1'b1});
        exp_page  = pg;
        rd_k      = 8'h00;
        base_wr   = wr_count;
        base_done = done_cnt;
`ifdef OBM_DMA_VBLANK_WAIT_EN
        exp_done  = (vbl_low > 0) ? vbl_low + 513 : 514;
`else
        exp_done  = 513;
`endif
        if (vbl_low > 0) vblank_i = 1'b0;
        @(posedge cpu_clk); #1;
        start_i = 1'b1;
        page_i  = pg;
        if (cpu_at_start) cpu_drive(1'b1);
        n = 0; got = 1'b0; aborted = 1'b0; done_n = 0;
        while (n < 1200 && !got && !aborted) begin
            @(posedge cpu_clk); #1;
            n++;
            start_i = 1'b0;
            cpu_drive(1'b0);
            if (n == 1) begin
                chk("busy_rise", busy_o, 1);
                chk("stall_rise", cpu_stall_o, 1);
            end
            if (n == restart_at) begin
                start_i = 1'b1;
                page_i  = 8'h05;
            end
            if (cpu_wr_at > 0 && n >= cpu_wr_at && n < cpu_wr_at + 6) cpu_drive(1'b1);
            if (vbl_low > 0 && n == vbl_low) begin
`ifdef OBM_DMA_VBLANK_WAIT_EN
                chk("vbl_hold_writes", wr_count - base_wr, 0);
`else
                chk("vbl_ignored", (wr_count - base_wr) > 0, 1);
`endif
                vblank_i = 1'b1;
            end
            if (abort_after > 0 && (wr_count - base_wr) >= abort_after) aborted = 1'b1;
            if (done_o) begin
                got    = 1'b1;
                done_n = n;
            end
        end
        if (aborted) begin
            rst_n = 1'b0;
            #1;
            chk("abort_busy", busy_o, 0);
            chk("abort_stall", cpu_stall_o, 0);
            chk("abort_done", done_o, 0);
            repeat (2) @(posedge cpu_clk);
            #1;
            rst_n = 1'b1;
            exp_q.delete();
            base_wr = wr_count;
            repeat (20) @(posedge cpu_clk);
            #1;
            chk("abort_no_wr", wr_count - base_wr, 0);
            chk("abort_no_done", done_cnt - base_done, 0);
            chk("abort_idle_busy", busy_o, 0);
        end else begin
            chk("done_cycle", done_n, exp_done);
            @(posedge cpu_clk); #1;
            chk("done_one_cycle", done_o, 0);
            chk("busy_fall", busy_o, 0);
            chk("done_pulses", done_cnt - base_done, 1);
            chk("all_writes", exp_q.size(), 0);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) obm_m[k] = 8'h00;
        cpu_wen_i          = 1'b1;
        cpu_vram_address_i = 12'h123;
        cpu_data_i         = 8'h77;
        cpu_SELECT_pmf_i   = 1'b1;
        repeat (3) @(posedge cpu_clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_mem_ren", mem_ren_o, 0);
        chk("rst_wen_pass", wen_o, 1);
        chk("rst_addr_pass", vram_address_o, 12'h123);
        chk("rst_data_pass", data_o, 8'h77);
        cpu_wen_i = 1'b0;
        rst_n     = 1'b1;

        // Idle CPU write to PMF passes through.
        @(posedge cpu_clk); #1;
        exp_q.push_back('{12'h000, 8'h3C, 1'b1, 1'b0});
        cpu_drive(1'b1);
        #1;
        chk("idle_addr", vram_address_o, 12'h000);
        chk("idle_data", data_o, 8'h3C);
        chk("idle_pmf", SELECT_pmf_o, 1);
        @(posedge cpu_clk); #1;
        cpu_drive(1'b0);
        chk("idle_wr_seen", exp_q.size(), 0);

        run_xfer(8'h02, 0, 0, 1'b0, 0, 0);
        check_obm("obm_full", 256, 8'h00);

        run_xfer(8'h02, 40, 100, 1'b1, 0, 0);
        run_xfer(8'h02, 0, 0, 1'b0, 0, 100);

        for (int k = 0; k < 256; k++) obm_m[k] = 8'hEE;
        run_xfer(8'h02, 0, 0, 1'b0, 77, 0);
        check_obm("obm_abort", 77, 8'hEE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
